// File: rtl/occ_rom_arbiter.sv
// Round-robin arbiter that shares the single rom_Occ read port among NUM_REQ
// FM-index search lanes, with one outstanding access and a per-access timeout.
module occ_rom_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      busy_o,
  output logic                      ce_rom_Occ_o,
  output logic [ADDR_W-1:0]         addr_rom_Occ_o,
  input  logic [DATA_W-1:0]         data_Occ_i,
  input  logic                      data_Occ_valid_i
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state, state_n;
  logic [7:0]         cnt, cnt_n;
  logic [IDW-1:0]     id, id_n;
  logic [IDW-1:0]     last_grant, last_grant_n;
  logic [IDW-1:0]     sel;
  logic               found;
  int unsigned        idx;

  logic [NUM_REQ-1:0] gnt_n, rvalid_n, err_n;
  logic [DATA_W-1:0]  rdata_n;
  logic               ce_n, busy_n;
  logic [ADDR_W-1:0]  addr_n;

  // Search upward from last_grant+1 with wrap; first hit wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_grant) + i) % NUM_REQ;
      if (!found && req_i[idx[IDW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IDW-1:0];
      end
    end
  end

  // Next-state logic also computes the next value of every registered output.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    id_n         = id;
    last_grant_n = last_grant;
    gnt_n        = '0;
    rvalid_n     = '0;
    err_n        = '0;
    rdata_n      = '0;
    ce_n         = 1'b0;
    addr_n       = addr_rom_Occ_o;
    case (state)
      IDLE: begin
        if (found) begin
          id_n       = sel;
          addr_n     = addr_i[sel*ADDR_W +: ADDR_W];
          gnt_n[sel] = 1'b1;
          ce_n       = 1'b1;
          cnt_n      = '0;
          state_n    = ACCESS;
        end
      end
      ACCESS: begin
        ce_n  = 1'b1;
        cnt_n = cnt + 8'd1;
        if (data_Occ_valid_i) begin
          rdata_n      = data_Occ_i;
          rvalid_n[id] = 1'b1;
          ce_n         = 1'b0;
          state_n      = RESP;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          rdata_n      = '0;
          rvalid_n[id] = 1'b1;
          err_n[id]    = 1'b1;
          ce_n         = 1'b0;
          state_n      = RESP;
        end
      end
      RESP: begin
        last_grant_n = id;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      id             <= '0;
      last_grant     <= IDW'(NUM_REQ - 1);
      gnt_o          <= '0;
      rvalid_o       <= '0;
      err_o          <= '0;
      rdata_o        <= '0;
      busy_o         <= 1'b0;
      ce_rom_Occ_o   <= 1'b0;
      addr_rom_Occ_o <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      id             <= id_n;
      last_grant     <= last_grant_n;
      gnt_o          <= gnt_n;
      rvalid_o       <= rvalid_n;
      err_o          <= err_n;
      rdata_o        <= rdata_n;
      busy_o         <= busy_n;
      ce_rom_Occ_o   <= ce_n;
      addr_rom_Occ_o <= addr_n;
    end
  end

endmodule

// File: tb/tb_occ_rom_arbiter.sv
// Directed bench for occ_rom_arbiter: reset, single access, round-robin order,
// timeout, withdrawn request and asynchronous reset mid-access.
module tb_occ_rom_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  req_i = '0;
  logic [NR*AW-1:0] addr_i = '0;
  logic [NR-1:0]  gnt_o, rvalid_o, err_o;
  logic [DW-1:0]  rdata_o;
  logic           busy_o, ce_rom_Occ_o;
  logic [AW-1:0]  addr_rom_Occ_o;
  logic [DW-1:0]  data_Occ_i;
  logic           data_Occ_valid_i;

  logic           rom_valid = 1'b0;
  logic           fixed_en = 1'b0;
  logic [DW-1:0]  fixed_data = '0;

  int unsigned total = 0;
  int unsigned bad = 0;

  occ_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
    .busy_o(busy_o), .ce_rom_Occ_o(ce_rom_Occ_o), .addr_rom_Occ_o(addr_rom_Occ_o),
    .data_Occ_i(data_Occ_i), .data_Occ_valid_i(data_Occ_valid_i)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [7:0] a);
    return {8'hA5, a, ~a, a ^ 8'h5A};
  endfunction

  assign data_Occ_i       = fixed_en ? fixed_data : rom_word(addr_rom_Occ_o);
  assign data_Occ_valid_i = rom_valid;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++; if (gnt_o !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt_o); end
    total++; if (rvalid_o !== 4'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid_o); end
    total++; if (err_o !== 4'b0) begin bad++; $display("FAIL reset_err got=%b exp=0000", err_o); end
    total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
    total++; if (busy_o !== 1'b0 || ce_rom_Occ_o !== 1'b0) begin bad++; $display("FAIL reset_busy_ce got=%b%b exp=00", busy_o, ce_rom_Occ_o); end
    total++; if (addr_rom_Occ_o !== 8'h0) begin bad++; $display("FAIL reset_addr got=%h exp=00", addr_rom_Occ_o); end
  endtask

  task automatic test_single();
    rst = 1'b0;
    rom_valid = 1'b1;
    fixed_en = 1'b1;
    fixed_data = 32'hDEADBEEF;
    addr_i[2*AW +: AW] = 8'h3C;
    req_i = 4'b0100;
    tick();
    total++; if (gnt_o !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b exp=0100", gnt_o); end
    total++; if (ce_rom_Occ_o !== 1'b1 || addr_rom_Occ_o !== 8'h3C) begin bad++; $display("FAIL single_rom ce=%b addr=%h exp ce=1 addr=3c", ce_rom_Occ_o, addr_rom_Occ_o); end
    total++; if (busy_o !== 1'b1 || rvalid_o !== 4'b0) begin bad++; $display("FAIL single_busy busy=%b rvalid=%b exp 1/0000", busy_o, rvalid_o); end
    req_i = '0;
    tick();
    total++; if (rvalid_o !== 4'b0100) begin bad++; $display("FAIL single_rvalid got=%b exp=0100", rvalid_o); end
    total++; if (rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata got=%h exp=deadbeef", rdata_o); end
    total++; if (err_o !== 4'b0 || gnt_o !== 4'b0 || ce_rom_Occ_o !== 1'b0) begin bad++; $display("FAIL single_resp err=%b gnt=%b ce=%b exp 0000/0000/0", err_o, gnt_o, ce_rom_Occ_o); end
    tick();
    total++; if (rvalid_o !== 4'b0 || rdata_o !== 32'h0 || busy_o !== 1'b0) begin bad++; $display("FAIL single_idle rvalid=%b rdata=%h busy=%b exp 0000/0/0", rvalid_o, rdata_o, busy_o); end
    fixed_en = 1'b0;
  endtask

  task automatic test_all_lanes();
    logic [NR-1:0] exp;
    do_reset();
    rom_valid = 1'b1;
    for (int unsigned k = 0; k < NR; k++) addr_i[k*AW +: AW] = 8'(8'h10 + k);
    req_i = 4'b1111;
    for (int unsigned g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % 4);
      tick();
      total++; if (gnt_o !== exp) begin bad++; $display("FAIL all_gnt%0d got=%b exp=%b", g, gnt_o, exp); end
      tick();
      total++; if (rvalid_o !== exp) begin bad++; $display("FAIL all_rvalid%0d got=%b exp=%b", g, rvalid_o, exp); end
      total++; if (rdata_o !== rom_word(8'(8'h10 + (g % 4)))) begin bad++; $display("FAIL all_rdata%0d got=%h exp=%h", g, rdata_o, rom_word(8'(8'h10 + (g % 4)))); end
      tick();
      total++; if (gnt_o !== 4'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL all_idle%0d gnt=%b busy=%b exp 0000/0", g, gnt_o, busy_o); end
    end
    req_i = '0;
  endtask

  task automatic test_round_robin();
    rom_valid = 1'b1;
    addr_i[1*AW +: AW] = 8'h61;
    addr_i[3*AW +: AW] = 8'h63;
    req_i = 4'b0010;
    tick();
    total++; if (gnt_o !== 4'b0010) begin bad++; $display("FAIL rr_first got=%b exp=0010", gnt_o); end
    req_i = '0;
    tick();
    tick();
    req_i = 4'b1010;
    tick();
    total++; if (gnt_o !== 4'b1000) begin bad++; $display("FAIL rr_lane3 got=%b exp=1000", gnt_o); end
    req_i = 4'b0010;
    tick();
    total++; if (rvalid_o !== 4'b1000 || rdata_o !== rom_word(8'h63)) begin bad++; $display("FAIL rr_resp3 rvalid=%b rdata=%h exp 1000/%h", rvalid_o, rdata_o, rom_word(8'h63)); end
    tick();
    tick();
    total++; if (gnt_o !== 4'b0010) begin bad++; $display("FAIL rr_lane1 got=%b exp=0010", gnt_o); end
    req_i = '0;
    tick();
    total++; if (rvalid_o !== 4'b0010 || rdata_o !== rom_word(8'h61)) begin bad++; $display("FAIL rr_resp1 rvalid=%b rdata=%h exp 0010/%h", rvalid_o, rdata_o, rom_word(8'h61)); end
    tick();
  endtask

  task automatic test_timeout();
    rom_valid = 1'b0;
    addr_i[0 +: AW] = 8'h20;
    req_i = 4'b0001;
    tick();
    total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL to_gnt got=%b exp=0001", gnt_o); end
    req_i = '0;
    for (int unsigned c = 2; c <= TO; c++) begin
      tick();
      total++; if (rvalid_o !== 4'b0 || ce_rom_Occ_o !== 1'b1) begin bad++; $display("FAIL to_wait%0d rvalid=%b ce=%b exp 0000/1", c, rvalid_o, ce_rom_Occ_o); end
    end
    tick();
    total++; if (rvalid_o !== 4'b0001 || err_o !== 4'b0001) begin bad++; $display("FAIL to_pulse rvalid=%b err=%b exp 0001/0001", rvalid_o, err_o); end
    total++; if (rdata_o !== 32'h0 || ce_rom_Occ_o !== 1'b0) begin bad++; $display("FAIL to_data rdata=%h ce=%b exp 0/0", rdata_o, ce_rom_Occ_o); end
    tick();
    rom_valid = 1'b1;
    addr_i[2*AW +: AW] = 8'h30;
    req_i = 4'b0100;
    tick();
    total++; if (gnt_o !== 4'b0100) begin bad++; $display("FAIL to_next_gnt got=%b exp=0100", gnt_o); end
    req_i = '0;
    tick();
    total++; if (rvalid_o !== 4'b0100 || err_o !== 4'b0 || rdata_o !== rom_word(8'h30)) begin bad++; $display("FAIL to_next_resp rvalid=%b err=%b rdata=%h", rvalid_o, err_o, rdata_o); end
    tick();
    rom_valid = 1'b0;
    addr_i[1*AW +: AW] = 8'h40;
    req_i = 4'b0010;
    tick();
    total++; if (gnt_o !== 4'b0010) begin bad++; $display("FAIL late_gnt got=%b exp=0010", gnt_o); end
    req_i = '0;
    for (int unsigned c = 2; c <= TO; c++) tick();
    rom_valid = 1'b1;
    tick();
    total++; if (rvalid_o !== 4'b0010 || err_o !== 4'b0) begin bad++; $display("FAIL late_resp rvalid=%b err=%b exp 0010/0000", rvalid_o, err_o); end
    total++; if (rdata_o !== rom_word(8'h40)) begin bad++; $display("FAIL late_rdata got=%h exp=%h", rdata_o, rom_word(8'h40)); end
    tick();
  endtask

  task automatic test_withdraw();
    rom_valid = 1'b0;
    addr_i[2*AW +: AW] = 8'h50;
    addr_i[0 +: AW] = 8'h51;
    req_i = 4'b0100;
    tick();
    total++; if (gnt_o !== 4'b0100) begin bad++; $display("FAIL wd_gnt got=%b exp=0100", gnt_o); end
    req_i = 4'b0001;
    tick();
    tick();
    req_i = '0;
    rom_valid = 1'b1;
    tick();
    total++; if (rvalid_o !== 4'b0100) begin bad++; $display("FAIL wd_resp got=%b exp=0100", rvalid_o); end
    for (int unsigned c = 0; c < 4; c++) begin
      tick();
      total++; if (gnt_o !== 4'b0 || rvalid_o !== 4'b0) begin bad++; $display("FAIL wd_quiet%0d gnt=%b rvalid=%b exp 0000/0000", c, gnt_o, rvalid_o); end
    end
  endtask

  task automatic test_reset_mid();
    rom_valid = 1'b0;
    addr_i[1*AW +: AW] = 8'h70;
    req_i = 4'b0010;
    tick();
    req_i = '0;
    tick();
    total++; if (ce_rom_Occ_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL rm_pre ce=%b busy=%b exp 1/1", ce_rom_Occ_o, busy_o); end
    #2 rst = 1'b1;
    #1;
    total++; if (ce_rom_Occ_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL rm_async ce=%b busy=%b exp 0/0", ce_rom_Occ_o, busy_o); end
    total++; if (gnt_o !== 4'b0 || rvalid_o !== 4'b0 || err_o !== 4'b0) begin bad++; $display("FAIL rm_pulses gnt=%b rvalid=%b err=%b exp 0", gnt_o, rvalid_o, err_o); end
    tick();
    rst = 1'b0;
    rom_valid = 1'b1;
    addr_i[0 +: AW] = 8'h80;
    addr_i[3*AW +: AW] = 8'h83;
    req_i = 4'b1001;
    tick();
    total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL rm_first got=%b exp=0001", gnt_o); end
    req_i = 4'b1000;
    tick();
    total++; if (rvalid_o !== 4'b0001 || rdata_o !== rom_word(8'h80)) begin bad++; $display("FAIL rm_resp0 rvalid=%b rdata=%h", rvalid_o, rdata_o); end
    tick();
    tick();
    total++; if (gnt_o !== 4'b1000 || addr_rom_Occ_o !== 8'h83) begin bad++; $display("FAIL rm_second gnt=%b addr=%h exp 1000/83", gnt_o, addr_rom_Occ_o); end
    req_i = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_lanes();
    test_round_robin();
    test_timeout();
    test_withdraw();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
